// File: rtl/sd_llfifo_sched_if.sv
// sd_llfifo_sched_if: srdy/drdy beat handshake carrying a queue id and a data beat.
// The master drives srdy/qid/data, the slave answers with drdy.
interface sd_llfifo_sched_if #(
    parameter int width  = 8,
    parameter int qid_sz = 3
) ();
    logic              srdy;
    logic              drdy;
    logic [qid_sz-1:0] qid;
    logic [width-1:0]  data;

    modport master (output srdy, output qid, output data, input drdy);
    modport slave  (input srdy, input qid, input data, output drdy);
endinterface

// File: rtl/sd_llfifo_sched.sv
// sd_llfifo_sched: dequeue scheduler for the linked-list multi-queue FIFO.
// Round-robin one-hot read requests gated by per-queue credits, a per-queue
// pending bit and an outstanding-read limit; returned beats pass through a
// 2-entry skid buffer to the downstream srdy/drdy port.
// Optional: define SD_LLFIFO_SCHED_ERR_EN to add a sticky err output that flags
// credit saturation and returns for queues with no read pending.
module sd_llfifo_sched #(
    parameter int width           = 8,
    parameter int num_queues      = 8,
    parameter int qid_sz          = $clog2(num_queues),
    parameter int credit_sz       = 4,
    parameter int init_credit     = 8,
    parameter int max_outstanding = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [num_queues-1:0] q_empty,
    output logic [num_queues-1:0] rd_req,
    input  logic [num_queues-1:0] cr_ret,
    sd_llfifo_sched_if.slave      ret_if,
    sd_llfifo_sched_if.master     out_if
`ifdef SD_LLFIFO_SCHED_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int oc_sz = $clog2(max_outstanding + 1);
    localparam logic [credit_sz-1:0] credit_max  = '1;
    localparam logic [credit_sz-1:0] credit_init = credit_sz'(init_credit);
    localparam logic [oc_sz-1:0]     out_max     = oc_sz'(max_outstanding);

    typedef logic [qid_sz+width-1:0] beat_t;

    logic [credit_sz-1:0]  credit_q [num_queues];
    logic [credit_sz-1:0]  credit_d [num_queues];
    logic [num_queues-1:0] pending_q, pending_d;
    logic [oc_sz-1:0]      outstanding_q, outstanding_d;
    logic [qid_sz-1:0]     rr_ptr_q, rr_ptr_d;
    logic [num_queues-1:0] rd_req_q, rd_req_d;
    beat_t                 skid_q [2];
    beat_t                 skid_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  drdy_q, drdy_d;

    logic [num_queues-1:0] eligible;
    logic [num_queues-1:0] grant;
    logic                  grant_any;
    logic [qid_sz-1:0]     grant_idx;
    logic                  ret_fire;
    logic                  out_fire;
    logic [num_queues-1:0] ret_hit;
    logic                  ret_known;
    beat_t                 head;

    // A queue may be read when it has data, credit, no read in flight, and
    // the global outstanding limit has room.
    always_comb begin
        eligible = '0;
        for (int q = 0; q < num_queues; q++) begin
            eligible[q] = ~q_empty[q] & (credit_q[q] != '0) & ~pending_q[q]
                          & (outstanding_q < out_max);
        end
    end

    // Round-robin pick: first eligible queue searching upward from rr_ptr, with wrap.
    always_comb begin
        int                sum;
        logic [qid_sz-1:0] idx;
        sum       = 0;
        idx       = '0;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < num_queues; i++) begin
            sum = int'(rr_ptr_q) + i;
            if (sum >= num_queues) begin
                sum = sum - num_queues;
            end
            idx = qid_sz'(sum);
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Decode an accepted return; only a return matching a pending read retires
    // an outstanding slot, so late beats after init never underflow the count.
    always_comb begin
        ret_fire = ret_if.srdy & drdy_q;
        out_fire = (count_q != 2'd0) & out_if.drdy;
        ret_hit  = '0;
        for (int q = 0; q < num_queues; q++) begin
            ret_hit[q] = ret_fire & (ret_if.qid == qid_sz'(q));
        end
        ret_known = |(ret_hit & pending_q);
    end

    // Scheduler bookkeeping: credits, pending bits, outstanding count, pointer, request.
    always_comb begin
        int nxt;
        nxt = int'(grant_idx) + 1;
        if (nxt >= num_queues) begin
            nxt = 0;
        end
        for (int q = 0; q < num_queues; q++) begin
            credit_d[q] = credit_q[q];
            if (grant[q] && !cr_ret[q]) begin
                credit_d[q] = credit_q[q] - credit_sz'(1);
            end else if (!grant[q] && cr_ret[q] && (credit_q[q] != credit_max)) begin
                credit_d[q] = credit_q[q] + credit_sz'(1);
            end
        end
        // grant can never target a queue that is being retired (it was pending).
        pending_d     = (pending_q & ~ret_hit) | grant;
        outstanding_d = outstanding_q + oc_sz'(grant_any) - oc_sz'(ret_known);
        rr_ptr_d      = grant_any ? qid_sz'(nxt) : rr_ptr_q;
        rd_req_d      = grant;
    end

    // Two-entry skid buffer; drdy is registered from the next occupancy.
    always_comb begin
        skid_d   = skid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (ret_fire) begin
            skid_d[wr_ptr_q] = {ret_if.qid, ret_if.data};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (out_fire) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, ret_fire} - {1'b0, out_fire};
        drdy_d  = (count_d != 2'd2);
    end

    // Control state; reset and init both reload everything and flush the buffer.
    always_ff @(posedge clk) begin
        if (!reset || init) begin
            for (int q = 0; q < num_queues; q++) begin
                credit_q[q] <= credit_init;
            end
            pending_q     <= '0;
            outstanding_q <= '0;
            rr_ptr_q      <= '0;
            rd_req_q      <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            drdy_q        <= 1'b0;
        end else begin
            credit_q      <= credit_d;
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            rr_ptr_q      <= rr_ptr_d;
            rd_req_q      <= rd_req_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            drdy_q        <= drdy_d;
        end
    end

    // Skid storage is pure datapath; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign head        = skid_q[rd_ptr_q];
    assign rd_req      = rd_req_q;
    assign ret_if.drdy = drdy_q;
    assign out_if.srdy = (count_q != 2'd0);
    assign out_if.qid  = head[qid_sz+width-1:width];
    assign out_if.data = head[width-1:0];

`ifdef SD_LLFIFO_SCHED_ERR_EN
    logic                  err_q, err_d;
    logic [num_queues-1:0] cr_sat;

    // Sticky error: a credit return that would overflow, or a beat with no read pending.
    always_comb begin
        cr_sat = '0;
        for (int q = 0; q < num_queues; q++) begin
            cr_sat[q] = cr_ret[q] & ~grant[q] & (credit_q[q] == credit_max);
        end
        err_d = err_q | (|cr_sat) | (ret_fire & ~ret_known);
    end

    // Error flag holds until reset or init.
    always_ff @(posedge clk) begin
        if (!reset || init) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule
